// File: rtl/mn_spike_counter.sv
// Spike counter for the time-multiplexed motoneuron pool: sums sampled spikes per
// frame over a programmable window and publishes total and per-frame peak.
module mn_spike_counter #(
  parameter int unsigned NN           = 8,
  parameter logic [1:0]  SAMPLE_STATE = 2'h2,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic               neuron_clk,
  input  logic               reset_sim_n,
  input  logic               i_enable,
  input  logic               MN_spike,
  input  logic [NN+2:0]      neuronCounter,
  input  logic [15:0]        i_window_frames,
  input  logic               count_ack,
  input  logic               clr_overrun,
  output logic [COUNT_W-1:0] spike_count_out,
  output logic [NN+1:0]      frame_peak_out,
  output logic               count_valid,
  output logic               overrun
);

  localparam int unsigned FW = NN + 2;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [FW-1:0]      frame_acc_reg, frame_acc_next;
  logic [COUNT_W-1:0] win_acc_reg, win_acc_next;
  logic [FW-1:0]      peak_reg, peak_next;
  logic [15:0]        frame_cnt_reg, frame_cnt_next;
  logic [15:0]        win_len_reg, win_len_next;
  logic [COUNT_W-1:0] count_out_reg, count_out_next;
  logic [FW-1:0]      peak_out_reg, peak_out_next;
  logic               valid_reg, valid_next;
  logic               overrun_reg, overrun_next;

  logic               sample;
  logic               frame_end;
  logic               spike_hit;
  logic               window_end;
  logic               publish;
  logic [FW-1:0]      frame_total;
  logic [COUNT_W:0]   win_sum;
  logic [COUNT_W-1:0] win_sat;
  logic [FW-1:0]      peak_upd;
  logic [15:0]        win_len_req;

  assign sample      = (neuronCounter[1:0] == SAMPLE_STATE);
  assign frame_end   = &neuronCounter;
  assign spike_hit   = sample & MN_spike;

  // Frame total includes a spike sampled in the same cycle as frame_end.
  assign frame_total = frame_acc_reg + FW'(spike_hit);
  assign win_sum     = {1'b0, win_acc_reg} + (COUNT_W + 1)'(frame_total);
  assign win_sat     = win_sum[COUNT_W] ? {COUNT_W{1'b1}} : win_sum[COUNT_W-1:0];
  assign peak_upd    = (frame_total > peak_reg) ? frame_total : peak_reg;
  assign win_len_req = (i_window_frames == 16'd0) ? 16'd1 : i_window_frames;
  assign window_end  = frame_end && (frame_cnt_reg == (win_len_reg - 16'd1));

  always_ff @(posedge neuron_clk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      state_reg     <= ST_SYNC;
      frame_acc_reg <= '0;
      win_acc_reg   <= '0;
      peak_reg      <= '0;
      frame_cnt_reg <= '0;
      win_len_reg   <= '0;
      count_out_reg <= '0;
      peak_out_reg  <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_acc_reg <= frame_acc_next;
      win_acc_reg   <= win_acc_next;
      peak_reg      <= peak_next;
      frame_cnt_reg <= frame_cnt_next;
      win_len_reg   <= win_len_next;
      count_out_reg <= count_out_next;
      peak_out_reg  <= peak_out_next;
      valid_reg     <= valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    frame_acc_next = frame_acc_reg;
    win_acc_next   = win_acc_reg;
    peak_next      = peak_reg;
    frame_cnt_next = frame_cnt_reg;
    win_len_next   = win_len_reg;
    publish        = 1'b0;

    case (state_reg)
      ST_SYNC: begin
        // Idle until a frame boundary so the first counted frame is complete.
        frame_acc_next = '0;
        win_acc_next   = '0;
        peak_next      = '0;
        frame_cnt_next = '0;
        if (frame_end && i_enable) begin
          state_next   = ST_COUNT;
          win_len_next = win_len_req;
        end
      end

      ST_COUNT: begin
        if (!i_enable) begin
          state_next     = ST_SYNC;
          frame_acc_next = '0;
          win_acc_next   = '0;
          peak_next      = '0;
          frame_cnt_next = '0;
        end else if (frame_end) begin
          frame_acc_next = '0;
          if (window_end) begin
            publish        = 1'b1;
            win_acc_next   = '0;
            peak_next      = '0;
            frame_cnt_next = '0;
            win_len_next   = win_len_req;
          end else begin
            win_acc_next   = win_sat;
            peak_next      = peak_upd;
            frame_cnt_next = frame_cnt_reg + 16'd1;
          end
        end else if (spike_hit) begin
          frame_acc_next = frame_acc_reg + FW'(1);
        end
      end

      default: begin
        state_next = ST_SYNC;
      end
    endcase
  end

  // Result holding register and handshake; a publish always wins over ack.
  always_comb begin
    count_out_next = count_out_reg;
    peak_out_next  = peak_out_reg;
    valid_next     = valid_reg;
    overrun_next   = overrun_reg;

    if (publish) begin
      count_out_next = win_sat;
      peak_out_next  = peak_upd;
      valid_next     = 1'b1;
    end else if (count_ack) begin
      valid_next     = 1'b0;
    end

    if (publish && valid_reg && !count_ack) begin
      overrun_next = 1'b1;
    end else if (clr_overrun) begin
      overrun_next = 1'b0;
    end
  end

  assign spike_count_out = count_out_reg;
  assign frame_peak_out  = peak_out_reg;
  assign count_valid     = valid_reg;
  assign overrun         = overrun_reg;

endmodule

// File: doc/mn_spike_counter.md
Name: mn_spike_counter

Overview:
- Downstream consumer of the motoneuron pool's time-multiplexed MN_spike stream.
- Samples one spike bit per neuron slot and sums spikes across all neurons per frame.
- Accumulates frames over a programmable window, then publishes total count and per-frame peak through a valid/ack holding register.
- Output feeds the host readout and muscle-force stages.

Parameters:
- NN, 8, pool size exponent; NUM_NEURON = 2^(NN+1); frame = 2^(NN+3) clock cycles.
- SAMPLE_STATE, 2'h2, value of neuronCounter[1:0] on which MN_spike is valid and sampled.
- COUNT_W, 32, width of window accumulator and spike_count_out.

Ports:
- neuron_clk  in  1  sole clock; all logic on posedge.
- reset_sim_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  counting enable.
- MN_spike  in  1  spike bit of current neuron slot.
- neuronCounter  in  NN+3  pool slot counter: [1:0] state, [NN+2:2] neuron index.
- i_window_frames  in  16  window length in frames; 0 treated as 1.
- count_ack  in  1  host acknowledge of published result.
- clr_overrun  in  1  clears sticky overrun.
- spike_count_out  out  COUNT_W  total spikes in last completed window.
- frame_peak_out  out  NN+2  max single-frame spike count within last window.
- count_valid  out  1  result held and unacknowledged.
- overrun  out  1  sticky; a window completed while count_valid=1 and no ack that cycle.

Behaviour:
- Reset (async assert, sync-safe release): all outputs 0; accumulators, frame counter, and window-length latch cleared; FSM to SYNC.
- Decodes:
  - sample = neuronCounter[1:0]==SAMPLE_STATE.
  - frame_end = neuronCounter all ones.
- FSM SYNC:
  - Nothing accumulated.
  - Leaves to COUNT on first frame_end with i_enable=1.
  - Latches win_len = max(i_window_frames,1).
  - Clears frame_acc, win_acc, peak, frame_cnt.
- FSM COUNT:
  - On sample with MN_spike=1: frame_acc += 1.
  - On frame_end:
    - frame_acc plus any same-cycle sample added to win_acc; win_acc saturates at all-ones.
    - peak = max(peak, that frame total); frame_acc cleared.
    - frame_cnt += 1.
  - Window end = frame_end with frame_cnt == win_len-1.
    - Next cycle: spike_count_out and frame_peak_out updated, count_valid=1.
    - win_acc, peak, frame_cnt cleared.
    - win_len relatched from i_window_frames.
    - Latency from frame_end to valid: 1 cycle.
  - i_enable=0 in COUNT:
    - Immediately (next edge) return to SYNC, discard partial window.
    - Published outputs and count_valid unchanged.
- i_window_frames changes mid-window take effect only at next window start.
- Handshake:
  - count_ack with count_valid=1 clears count_valid next cycle.
  - Ack with count_valid=0 ignored.
  - Publish and ack in same cycle: publish wins, count_valid stays 1, no overrun.
  - Publish while count_valid=1 and no ack: outputs overwritten with new window, overrun set.
- overrun stays set until clr_overrun=1 or reset. If set and cleared in the same cycle, set wins.
- Only the slot with SAMPLE_STATE is sampled; MN_spike in other states is ignored, so at most one count per neuron per frame.
- frame_acc width NN+2 never overflows; max value 2^(NN+1).
- Reset mid-window: everything lost, returns to SYNC; first partial frame after reset is never counted.

Test Plan (NN=2: 8 neurons, 32-cycle frame, neuronCounter free-running 0..31):
- Reset:
  - Stimulus: assert reset_sim_n=0 mid-frame with MN_spike=1.
  - Required: all outputs 0 immediately; after release, no count until first frame_end passes.
- Constant spikes:
  - Stimulus: MN_spike=1 constantly, window=1, enable=1, ack each publish.
  - Required: every frame publishes spike_count_out=8, frame_peak_out=8; count_valid rises 1 cycle after neuronCounter=31.
- Single neuron:
  - Stimulus: MN_spike=1 only when neuron index=3 and state=2, window=4.
  - Required: spike_count_out=4, frame_peak_out=1 every 128 cycles.
- Zero window and mid-window change:
  - Stimulus: window=0 with same pattern.
  - Required: behaves as window=1, count=1 per frame.
  - Stimulus: change window 4→2 mid-window.
  - Required: current window still 4 frames, next window 2.
- Overrun and handshake:
  - Stimulus: no ack across two windows.
  - Required: overrun=1, outputs show second window.
  - Stimulus: ack coincident with publish.
  - Required: count_valid stays 1, overrun unchanged.
  - Stimulus: clr_overrun.
  - Required: overrun=0.
- Enable drop:
  - Stimulus: i_enable=0 at frame 2 of a 4-frame window, re-enable later.
  - Required: partial window discarded; next published count covers a full 4 frames after resync.
